// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one iteration per cycle, stalling the pipeline while busy.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; operands latched on the accepting edge
// S_RUN  | 32 iterations of shift-add or restoring divide
// S_DONE | result valid for one cycle, then back to S_IDLE
module mdu_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall_req,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  op_q;
   logic        neg_q;
   logic [4:0]  cnt;
   logic [63:0] acc;
   logic [31:0] mcand;

   logic        sgn_a;
   logic        sgn_b;
   logic        neg_a;
   logic        neg_b;
   logic        neg_in;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        div_zero;
   logic        div_ovf;
   logic        special;
   logic [31:0] special_res;

   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] div_next;
   logic [63:0] step;
   logic [63:0] mul_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] final_res;

   // Operand decode at acceptance: signedness, magnitudes and the result sign.
   always_comb begin
      sgn_a = op[2] ? ~op[0] : ((op == OP_MULH) || (op == OP_MULHSU));
      sgn_b = op[2] ? ~op[0] : (op == OP_MULH);
      neg_a = sgn_a & src_a[31];
      neg_b = sgn_b & src_b[31];
      mag_a = neg_a ? (~src_a + 32'd1) : src_a;
      mag_b = neg_b ? (~src_b + 32'd1) : src_b;
      neg_in = (op[2] & op[1]) ? neg_a : (neg_a ^ neg_b);
      div_zero = op[2] & (src_b == 32'd0);
      div_ovf  = op[2] & ~op[0] & (src_a == 32'h8000_0000) & (src_b == 32'hFFFF_FFFF);
      special  = div_zero | div_ovf;
      if (div_zero)
         special_res = op[1] ? src_a : 32'hFFFF_FFFF;
      else
         special_res = op[1] ? 32'd0 : 32'h8000_0000;
   end

   // One iteration. acc holds {partial_hi, multiplier} or {remainder, quotient}.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
      mul_next  = {mul_sum, acc[31:1]};
      div_shift = {acc[63:32], acc[31]};
      div_diff  = div_shift - {1'b0, mcand};
      if (!div_diff[32])
         div_next = {div_diff[31:0], acc[30:0], 1'b1};
      else
         div_next = {div_shift[31:0], acc[30:0], 1'b0};
      step    = op_q[2] ? div_next : mul_next;
      mul_fix = neg_q ? (~step + 64'd1) : step;
      quo_fix = neg_q ? (~step[31:0] + 32'd1) : step[31:0];
      rem_fix = neg_q ? (~step[63:32] + 32'd1) : step[63:32];
      case (op_q)
         OP_MUL:               final_res = mul_fix[31:0];
         3'd1, 3'd2, 3'd3:     final_res = mul_fix[63:32];
         3'd4, 3'd5:           final_res = quo_fix;
         default:              final_res = rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_req = 1'b0;
      case (state)
         S_IDLE: begin
            stall_req = start;
            if (start)
               state_nxt = special ? S_DONE : S_RUN;
         end
         S_RUN: begin
            stall_req = 1'b1;
            if (cnt == 5'd0)
               state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush)
         state_nxt = S_IDLE;
   end

   assign done = (state == S_DONE);

   // Datapath freezes under flush so result keeps its last computed value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= 3'd0;
         neg_q  <= 1'b0;
         cnt    <= 5'd0;
         acc    <= 64'd0;
         mcand  <= 32'd0;
         result <= 32'd0;
      end else if (!flush) begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q  <= op;
                  neg_q <= neg_in;
                  cnt   <= 5'd31;
                  acc   <= {32'd0, (op[2] ? mag_a : mag_b)};
                  mcand <= op[2] ? mag_b : mag_a;
                  if (special)
                     result <= special_res;
               end
            end
            S_RUN: begin
               acc <= step;
               if (cnt == 5'd0)
                  result <= final_res;
               else
                  cnt <= cnt - 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
